c2p_design_wrapper: RTL and testbench

Top-level wrapper of the Cartesian-to-polar (car2pol) subsystem for the spinning LED display. An AXI4-Lite slave port exposes two register banks:
- Bank 0 at 0x0000_0000 loads a polar-to-Cartesian index map.
- Bank 1 at 0x4000_0000 loads a Cartesian image.

Triggering bank 1 streams out the image re-sampled in polar order, one pixel per cycle. This stream drives the LED column logic.

---
 rtl/c2p_design_wrapper.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_c2p_design_wrapper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2p_design_wrapper.sv
// c2p_design_wrapper: AXI4-Lite loaded Cartesian-to-polar resampler.
// Bank 0 (addr[30]=0) loads a polar->Cartesian index map. Bank 1 (addr[30]=1)
// loads an image. A trigger on bank 1 streams img[map[k]] for
// k = 0 .. map_count-1, one beat per cycle, with no backpressure.
module c2p_design_wrapper #(
   parameter int MAP_DEPTH = 16,
   parameter int IMG_DEPTH = 16,
   parameter int PIX_W     = 8
) (
   input  logic                         sys_clock,
   input  logic                         reset,
   // write address
   input  logic [31:0]                  s_axi_awaddr,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   // write data
   input  logic [31:0]                  s_axi_wdata,
   input  logic [3:0]                   s_axi_wstrb,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   // write response
   output logic [1:0]                   s_axi_bresp,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   // read address
   input  logic [31:0]                  s_axi_araddr,
   input  logic                         s_axi_arvalid,
   output logic                         s_axi_arready,
   // read data
   output logic [31:0]                  s_axi_rdata,
   output logic [1:0]                   s_axi_rresp,
   output logic                         s_axi_rvalid,
   input  logic                         s_axi_rready,
   // polar pixel stream
   output logic [PIX_W-1:0]             out_pix,
   output logic [$clog2(MAP_DEPTH)-1:0] out_idx,
   output logic                         out_valid,
   output logic                         out_last
);

   localparam int MAP_AW = $clog2(MAP_DEPTH);
   localparam int IMG_AW = $clog2(IMG_DEPTH);

   // Pointer/count limits at pointer width; pointers need one extra bit to reach "full".
   localparam logic [MAP_AW:0] MAP_FULL = (MAP_AW+1)'(MAP_DEPTH);
   localparam logic [IMG_AW:0] IMG_FULL = (IMG_AW+1)'(IMG_DEPTH);
   localparam logic [MAP_AW:0] CNT_ONE  = (MAP_AW+1)'(1);

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_t;

   // ---------------------------------------------------------------- state
   state_t              state_q, state_d;

   logic                awready_q, awready_d;
   logic                bvalid_q, bvalid_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic [31:0]         rdata_q, rdata_d;

   logic [IMG_AW-1:0]   map_q [MAP_DEPTH];
   logic [PIX_W-1:0]    img_q [IMG_DEPTH];

   logic [MAP_AW:0]     map_wptr_q, map_wptr_d;
   logic [MAP_AW:0]     map_count_q, map_count_d;
   logic                map_ready_q, map_ready_d;
   logic [IMG_AW:0]     img_wptr_q, img_wptr_d;
   logic                err_q, err_d;

   logic [MAP_AW:0]     frame_cnt_q, frame_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [MAP_AW-1:0]   out_idx_q, out_idx_d;
   logic [PIX_W-1:0]    out_pix_q, out_pix_d;

   // ---------------------------------------------------------------- decode
   logic                wr_fire, rd_fire;
   logic                wr_bank, rd_bank;
   logic [1:0]          wr_reg, rd_reg;
   logic                map_we, img_we;
   logic                frame_start, frame_done;
   logic                busy;
   logic [31:0]         status;
   logic [31:0]         rd_mux;
   logic [MAP_AW-1:0]   map_widx;
   logic [IMG_AW-1:0]   img_widx;

   // A write commits on the edge where awready is high with both valids still present.
   assign wr_fire  = awready_q && s_axi_awvalid && s_axi_wvalid;
   assign rd_fire  = arready_q && s_axi_arvalid;

   assign wr_bank  = s_axi_awaddr[30];
   assign wr_reg   = s_axi_awaddr[3:2];
   assign rd_bank  = s_axi_araddr[30];
   assign rd_reg   = s_axi_araddr[3:2];

   assign map_widx = map_wptr_q[MAP_AW-1:0];
   assign img_widx = img_wptr_q[IMG_AW-1:0];

   // The frame ends on the edge after the beat flagged last.
   assign frame_done = busy && out_last_q;

   // Address bits outside the decode and the byte strobes are intentionally ignored.
   logic unused_bits;
   assign unused_bits = &{1'b0, s_axi_awaddr[31], s_axi_awaddr[29:4], s_axi_awaddr[1:0],
                          s_axi_araddr[31], s_axi_araddr[29:4], s_axi_araddr[1:0],
                          s_axi_wstrb, s_axi_wdata};

   // ---------------------------------------------------------------- frame FSM
   // FSM state register.
   always_ff @(posedge sys_clock or negedge reset) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: start on an accepted trigger, stop after the last beat.
   always_comb begin
      // NOTE: assign a default first so no path leaves the signal unassigned (no latch).
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (frame_start) state_d = ST_STREAM;
         ST_STREAM: if (out_last_q)  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == ST_STREAM);
   end

   // ---------------------------------------------------------------- AXI channels
   // Handshake generation: one-cycle ready pulses, valids held until accepted.
   always_comb begin
      awready_d = !awready_q && !bvalid_q && s_axi_awvalid && s_axi_wvalid;
      arready_d = !arready_q && !rvalid_q && s_axi_arvalid;

      bvalid_d = bvalid_q;
      if (wr_fire)                     bvalid_d = 1'b1;
      else if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;

      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   // STATUS word assembly.
   always_comb begin
      status        = 32'd0;
      status[0]     = map_ready_q;
      status[1]     = busy;
      status[2]     = err_q;
      status[15:8]  = 8'(map_count_q);
      status[23:16] = 8'(img_wptr_q);
   end

   // Read mux; sampled at the AR handshake, so a same-edge write is not yet visible.
   always_comb begin
      rd_mux = 32'd0;
      if (!rd_bank) begin
         case (rd_reg)
            2'd0:    rd_mux = 32'(map_wptr_q);
            2'd1:    rd_mux = 32'(map_ready_q);
            2'd2:    rd_mux = status;
            default: rd_mux = 32'd0;
         endcase
      end else begin
         case (rd_reg)
            2'd0:    rd_mux = 32'(img_wptr_q);
            2'd1:    rd_mux = 32'(busy);
            default: rd_mux = 32'd0;
         endcase
      end
   end

   // ---------------------------------------------------------------- register writes
   // Register-write decode: pointer, flag and error updates plus array write enables.
   always_comb begin
      map_wptr_d  = map_wptr_q;
      map_count_d = map_count_q;
      map_ready_d = map_ready_q;
      img_wptr_d  = img_wptr_q;
      err_d       = err_q;
      map_we      = 1'b0;
      img_we      = 1'b0;
      frame_start = 1'b0;

      if (wr_fire) begin
         if (!wr_bank) begin
            case (wr_reg)
               2'd0: begin
                  if (!map_ready_q && (map_wptr_q < MAP_FULL)) begin
                     map_we     = 1'b1;
                     map_wptr_d = map_wptr_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               2'd1: begin
                  if (s_axi_wdata[0]) begin
                     map_ready_d = 1'b1;
                     map_count_d = map_wptr_q;
                  end else begin
                     map_ready_d = 1'b0;
                     map_wptr_d  = '0;
                     map_count_d = '0;
                  end
               end
               default: ;
            endcase
         end else begin
            case (wr_reg)
               2'd0: begin
                  if (!busy && (img_wptr_q < IMG_FULL)) begin
                     img_we     = 1'b1;
                     img_wptr_d = img_wptr_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               2'd1: begin
                  if (s_axi_wdata[0]) begin
                     if (map_ready_q && (map_count_q != '0) && !busy) frame_start = 1'b1;
                     else                                              err_d       = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      // Image writes are refused while busy, so this never collides with img_we.
      if (frame_done) img_wptr_d = '0;
   end

   // ---------------------------------------------------------------- stream datapath
   // Beat generation: first beat on the trigger edge, then one per edge until last.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_idx_d   = out_idx_q;
      out_pix_d   = out_pix_q;

      if (frame_start) begin
         // map_count is latched here so later MAP_VALID writes leave the frame alone.
         frame_cnt_d = map_count_q;
         out_valid_d = 1'b1;
         out_idx_d   = '0;
         out_pix_d   = img_q[map_q[0]];
         out_last_d  = (map_count_q == CNT_ONE);
      end else if (frame_done) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_idx_d   = '0;
         out_pix_d   = '0;
      end else if (busy) begin
         out_idx_d   = out_idx_q + 1'b1;
         out_pix_d   = img_q[map_q[out_idx_d]];
         out_last_d  = ({1'b0, out_idx_d} == (frame_cnt_q - CNT_ONE));
      end
   end

   // ---------------------------------------------------------------- registers
   // Control, handshake and stream registers.
   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         awready_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         map_wptr_q  <= '0;
         map_count_q <= '0;
         map_ready_q <= 1'b0;
         img_wptr_q  <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         out_pix_q   <= '0;
      end else begin
         awready_q   <= awready_d;
         bvalid_q    <= bvalid_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         map_wptr_q  <= map_wptr_d;
         map_count_q <= map_count_d;
         map_ready_q <= map_ready_d;
         img_wptr_q  <= img_wptr_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_idx_q   <= out_idx_d;
         out_pix_q   <= out_pix_d;
      end
   end

   // Map and image storage.
   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the arrays are cleared on reset because never-written pixels must read 0;
         // this keeps them in flops rather than a RAM macro.
         for (int i = 0; i < MAP_DEPTH; i++) map_q[i] <= '0;
         for (int i = 0; i < IMG_DEPTH; i++) img_q[i] <= '0;
      end else begin
         if (map_we) map_q[map_widx] <= s_axi_wdata[IMG_AW-1:0];
         if (img_we) img_q[img_widx] <= s_axi_wdata[PIX_W-1:0];
      end
   end

   // ---------------------------------------------------------------- outputs
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;
   assign s_axi_rvalid  = rvalid_q;

   assign out_pix   = out_pix_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_c2p_design_wrapper.sv
// tb_c2p_design_wrapper: scoreboard bench for the car2pol wrapper.
// Expected beats are queued when a trigger is issued and popped by a monitor.
module tb_c2p_design_wrapper;

   localparam int MAP_DEPTH = 16;
   localparam int IMG_DEPTH = 16;
   localparam int PIX_W     = 8;

   logic        sys_clock = 1'b0;
   logic        reset     = 1'b0;
   logic [31:0] s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = 4'hF;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic [31:0] s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b1;
   logic [7:0]  out_pix;
   logic [3:0]  out_idx;
   logic        out_valid;
   logic        out_last;

   c2p_design_wrapper #(.MAP_DEPTH(MAP_DEPTH), .IMG_DEPTH(IMG_DEPTH), .PIX_W(PIX_W)) dut (
      .sys_clock(sys_clock), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .out_pix(out_pix), .out_idx(out_idx), .out_valid(out_valid), .out_last(out_last)
   );

   always #5 sys_clock = ~sys_clock;

   typedef struct {
      logic [7:0] pix;
      int         idx;
      logic       last;
   } beat_t;

   beat_t      exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   int         wr_hs = 0;
   logic [7:0] img_m [IMG_DEPTH];
   int         map_m [MAP_DEPTH];

   always @(posedge sys_clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Monitor: every valid beat must match the head of the scoreboard and its cycle.
   always @(negedge sys_clock) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_pix",   32'(out_pix),  32'(e.pix));
            check("beat_idx",   32'(out_idx),  32'(e.idx));
            check("beat_last",  32'(out_last), 32'(e.last));
            check("beat_cycle", 32'(cyc),      32'(wr_hs + 1 + e.idx));
         end
      end
   end

   task automatic push_frame(input int n);
      for (int k = 0; k < n; k++) begin
         beat_t b;
         b.pix  = img_m[map_m[k]];
         b.idx  = k;
         b.last = (k == n - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
      int n;
      @(negedge sys_clock);
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      n = 0;
      @(negedge sys_clock);
      while (!s_axi_awready && n < 20) begin
         @(negedge sys_clock);
         n++;
      end
      if (!s_axi_awready) begin
         check("aw_timeout", 32'd0, 32'd1);
         s_axi_awvalid = 1'b0;
         s_axi_wvalid  = 1'b0;
         return;
      end
      wr_hs = cyc;
      @(negedge sys_clock);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      check("bvalid", 32'(s_axi_bvalid), 32'd1);
      check("bresp",  32'(s_axi_bresp),  32'd0);
      @(negedge sys_clock);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      int n;
      @(negedge sys_clock);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      n = 0;
      @(negedge sys_clock);
      while (!s_axi_arready && n < 20) begin
         @(negedge sys_clock);
         n++;
      end
      if (!s_axi_arready) begin
         check("ar_timeout", 32'd0, 32'd1);
         s_axi_arvalid = 1'b0;
         data = 32'hDEAD_BEEF;
         return;
      end
      @(negedge sys_clock);
      s_axi_arvalid = 1'b0;
      check("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
      check("rresp",          32'(s_axi_rresp),  32'd0);
      data = s_axi_rdata;
      @(negedge sys_clock);
   endtask

   task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      check(tag, d, exp);
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(negedge sys_clock);
         n++;
      end
      if (n >= 200) begin
         check("frame_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge sys_clock);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < IMG_DEPTH; i++) img_m[i] = 8'h00;
      for (int i = 0; i < MAP_DEPTH; i++) map_m[i] = 0;

      // 1: reset state
      repeat (16) @(negedge sys_clock);
      check("rst_out_valid", 32'(out_valid),     32'd0);
      check("rst_out_pix",   32'(out_pix),       32'd0);
      check("rst_awready",   32'(s_axi_awready), 32'd0);
      check("rst_bvalid",    32'(s_axi_bvalid),  32'd0);
      check("rst_rvalid",    32'(s_axi_rvalid),  32'd0);
      reset = 1'b1;
      rd_check("t1_status", 32'h0000_0008, 32'h0000_0000);

      // 2: two-beat frame over unwritten pixels
      axi_write(32'h0000_0000, 32'd6);
      axi_write(32'h0000_0000, 32'd7);
      axi_write(32'h0000_0004, 32'd1);
      axi_write(32'h4000_0000, 32'd8);
      img_m[0] = 8'h08;
      rd_check("t2_status_pre", 32'h0000_0008, 32'h0001_0201);
      map_m[0] = 6;
      map_m[1] = 7;
      push_frame(2);
      axi_write(32'h4000_0004, 32'd1);
      wait_frame();
      rd_check("t2_status_post", 32'h0000_0008, 32'h0000_0201);
      rd_check("t2_img_wptr",    32'h4000_0000, 32'd0);
      rd_check("t2_busy",        32'h4000_0004, 32'd0);

      // 3: map {0,3,1} over image {11,22,33,44}
      axi_write(32'h0000_0004, 32'd0);
      axi_write(32'h0000_0000, 32'd0);
      axi_write(32'h0000_0000, 32'd3);
      axi_write(32'h0000_0000, 32'd1);
      axi_write(32'h0000_0004, 32'd1);
      for (int i = 0; i < 4; i++) begin
         axi_write(32'h4000_0000, 32'(32'h11 * (i + 1)));
         img_m[i] = 8'(32'h11 * (i + 1));
      end
      map_m[0] = 0;
      map_m[1] = 3;
      map_m[2] = 1;
      push_frame(3);
      axi_write(32'h4000_0004, 32'd1);
      wait_frame();
      rd_check("t3_status", 32'h0000_0008, 32'h0000_0301);

      // 4: refused trigger and write after MAP_VALID
      axi_write(32'h0000_0004, 32'd0);
      axi_write(32'h4000_0004, 32'd1);
      repeat (10) @(negedge sys_clock);
      rd_check("t4_status_err", 32'h0000_0008, 32'h0000_0004);
      axi_write(32'h0000_0000, 32'd5);
      axi_write(32'h0000_0004, 32'd1);
      axi_write(32'h0000_0000, 32'd9);
      rd_check("t4_status",   32'h0000_0008, 32'h0000_0105);
      rd_check("t4_map_wptr", 32'h0000_0000, 32'd1);

      // 5: overflow the map, then a full-depth frame, then clear
      axi_write(32'h0000_0004, 32'd0);
      for (int i = 0; i < 17; i++) axi_write(32'h0000_0000, 32'(i));
      for (int i = 0; i < 16; i++) map_m[i] = i;
      rd_check("t5_map_wptr", 32'h0000_0000, 32'd16);
      rd_check("t5_status",   32'h0000_0008, 32'h0000_0004);
      axi_write(32'h0000_0004, 32'd1);
      rd_check("t5_status_rdy", 32'h0000_0008, 32'h0000_1005);
      push_frame(16);
      axi_write(32'h4000_0004, 32'd1);
      wait_frame();
      axi_write(32'h0000_0004, 32'd0);
      rd_check("t5_wptr_clr",  32'h0000_0000, 32'd0);
      rd_check("t5_status_clr", 32'h0000_0008, 32'h0000_0004);
      rd_check("t5_map_valid", 32'h0000_0004, 32'd0);

      // 6: held write response with a concurrent read
      fork
         begin
            int n;
            @(negedge sys_clock);
            s_axi_bready  = 1'b0;
            s_axi_awaddr  = 32'h0000_000C;
            s_axi_wdata   = 32'd0;
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            n = 0;
            @(negedge sys_clock);
            while (!s_axi_awready && n < 20) begin
               @(negedge sys_clock);
               n++;
            end
            check("t6_awready_seen", 32'(s_axi_awready), 32'd1);
            @(negedge sys_clock);
            repeat (5) begin
               check("t6_bvalid_hold", 32'(s_axi_bvalid),  32'd1);
               check("t6_no_awready",  32'(s_axi_awready), 32'd0);
               @(negedge sys_clock);
            end
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            s_axi_bready  = 1'b1;
            @(negedge sys_clock);
            check("t6_bvalid_clear", 32'(s_axi_bvalid), 32'd0);
         end
         begin
            rd_check("t6_status", 32'h0000_0008, 32'h0000_0004);
         end
      join

      repeat (4) @(negedge sys_clock);
      check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
